full_adder_1bit: RTL and testbench

//   Single-bit binary full adder: adds operand bits A, B and carry-in Ci,

---
 rtl/full_adder_1bit.sv | 66 ++++++
 tb/tb_full_adder_1bit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/full_adder_1bit.sv
// ---------------------------------------------------------------------------
// full_adder_1bit
//   Single-bit binary full adder, leaf cell of the 64-bit ripple-carry chain
//   (Co of bit i feeds Ci of bit i+1).
//   OUT_REG = 0 : S/Co are purely combinational; clk/rst_n are ignored.
//   OUT_REG = 1 : S/Co are registered on the rising edge of clk, with an
//                 asynchronous active-low reset that clears both outputs.
// Ports
//   clk   in  1  clock (used only when OUT_REG = 1)
//   rst_n in  1  asynchronous active-low reset (used only when OUT_REG = 1)
//   Ci    in  1  carry-in
//   A     in  1  operand bit A
//   B     in  1  operand bit B
//   S     out 1  sum bit
//   Co    out 1  carry-out
// ---------------------------------------------------------------------------
module full_adder_1bit #(
  parameter bit OUT_REG = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic Ci,
  input  logic A,
  input  logic B,
  output logic S,
  output logic Co
);

  logic s_d;
  logic co_d;
  logic a_xor_b;

  always_comb begin
    a_xor_b = A ^ B;
    s_d     = a_xor_b ^ Ci;
    co_d    = (A & B) | (Ci & a_xor_b);
  end

  generate
    if (OUT_REG) begin : g_reg
      logic s_q;
      logic co_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q  <= 1'b0;
          co_q <= 1'b0;
        end else begin
          s_q  <= s_d;
          co_q <= co_d;
        end
      end

      assign S  = s_q;
      assign Co = co_q;
    end else begin : g_comb
      // clk/rst_n are intentionally unused in the combinational variant.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign S  = s_d;
      assign Co = co_d;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder_1bit.sv
module tb_full_adder_1bit;

  logic clk = 1'b0;
  logic rst_n;
  logic A, B, Ci;
  logic s_comb, co_comb;
  logic s_reg, co_reg;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  full_adder_1bit #(.OUT_REG(1'b0)) u_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .Ci    (Ci),
    .A     (A),
    .B     (B),
    .S     (s_comb),
    .Co    (co_comb)
  );

  full_adder_1bit #(.OUT_REG(1'b1)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .Ci    (Ci),
    .A     (A),
    .B     (B),
    .S     (s_reg),
    .Co    (co_reg)
  );

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got {Co,S}=%b expected %b at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer addition of the three operand bits.
  function automatic logic [1:0] ref_sum(input int a, input int b, input int c);
    int total;
    total = a + b + c;
    return total[1:0];
  endfunction

  task automatic apply(input int a, input int b, input int c);
    A  = a[0];
    B  = b[0];
    Ci = c[0];
  endtask

  int dir_a[4]  = '{1, 0, 1, 0};
  int dir_b[4]  = '{1, 1, 1, 0};
  int dir_c[4]  = '{0, 1, 1, 0};
  int dir_co[4] = '{0, 1, 1, 0};
  int dir_s[4]  = '{1, 0, 1, 0};

  initial begin
    logic [1:0] prev;
    logic [1:0] exp;
    int two;
    int ra, rb, rc;

    dir_b[0] = 0;

    // Reset state: registered copy cleared without any clock edge,
    // combinational copy stays valid under reset.
    rst_n = 1'b0;
    apply(1, 1, 0);
    #3;
    check("rst_reg_async", {co_reg, s_reg}, 2'b00);
    check("rst_comb_valid", {co_comb, s_comb}, 2'b10);
    @(negedge clk);
    check("rst_reg_hold", {co_reg, s_reg}, 2'b00);
    rst_n = 1'b1;

    // Directed vectors (time now aligned to a falling edge).
    for (int i = 0; i < 4; i++) begin
      apply(dir_a[i], dir_b[i], dir_c[i]);
      #10;
      check($sformatf("dir%0d", i + 1), {co_comb, s_comb}, {dir_co[i][0], dir_s[i][0]});
    end

    // Wide values truncated to their LSB by 1-bit regs: 2,2 -> 0,0.
    two = 2;
    A  = two[0];
    B  = two[0];
    Ci = 1'b0;
    #10;
    check("trunc_2_2", {co_comb, s_comb}, 2'b00);

    // Exhaustive combinational sweep.
    for (int v = 0; v < 8; v++) begin
      apply(v >> 2, v >> 1, v);
      #10;
      check($sformatf("comb_sweep%0d", v), {co_comb, s_comb}, ref_sum((v >> 2) & 1, (v >> 1) & 1, v & 1));
    end

    // Registered variant: one-cycle latency, exhaustive then random,
    // with a reset pulse asserted mid-run between clock edges.
    prev = ref_sum(1, 1, 1);
    for (int i = 0; i < 40; i++) begin
      if (i < 8) begin
        ra = (i >> 2) & 1; rb = (i >> 1) & 1; rc = i & 1;
      end else begin
        ra = int'($urandom_range(1, 0));
        rb = int'($urandom_range(1, 0));
        rc = int'($urandom_range(1, 0));
      end
      exp = ref_sum(ra, rb, rc);
      apply(ra, rb, rc);
      #1;
      check($sformatf("comb_rand%0d", i), {co_comb, s_comb}, exp);
      check($sformatf("reg_latency%0d", i), {co_reg, s_reg}, prev);
      if (i == 20) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_async", {co_reg, s_reg}, 2'b00);
        check("midrst_comb", {co_comb, s_comb}, exp);
        #6;
        check("midrst_hold", {co_reg, s_reg}, 2'b00);
        rst_n = 1'b1;
        prev = 2'b00;
      end else begin
        #9;
        check($sformatf("reg_out%0d", i), {co_reg, s_reg}, exp);
        prev = exp;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
